// File: rtl/async_fifo_rd_stream.sv
// Read-side consumer for the async FIFO. It pops the show-ahead read port into a
// registered 2-entry skid buffer (head/tail) and presents the words as a
// valid/ready stream. Occupancy and an accepted-beat counter are exported.
//
// Handshake: a beat transfers on a rising i_rclk edge where o_tvalid=1 and
// i_tready=1 ("fire"). While o_tvalid=1 and i_tready=0, o_tdata and o_tvalid
// stay stable; the only exception is i_flush, which drops o_tvalid. o_rinc is a
// pop strobe: the word on i_rdata is consumed at any edge where o_rinc=1.
module async_fifo_rd_stream #(
    parameter int DATA_WIDTH  = 8,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   i_rclk,
    input  logic                   i_rrst_n,
    input  logic [DATA_WIDTH-1:0]  i_rdata,
    input  logic                   i_rempty,
    output logic                   o_rinc,
    output logic [DATA_WIDTH-1:0]  o_tdata,
    output logic                   o_tvalid,
    input  logic                   i_tready,
    input  logic                   i_flush,
    output logic [1:0]             o_occupancy,
    output logic [COUNT_WIDTH-1:0] o_beat_count
);

    logic [1:0]             occ_q,   occ_d;
    logic [DATA_WIDTH-1:0]  head_q,  head_d;
    logic [DATA_WIDTH-1:0]  tail_q,  tail_d;
    logic [COUNT_WIDTH-1:0] beat_q,  beat_d;
    logic                   fire;
    logic                   pop;

    // Stream and pop controls come only from registered state and FIFO/flush
    // inputs, so i_tready never reaches o_rinc and i_rdata never reaches o_tdata.
    always_comb begin
        o_tvalid     = (occ_q != 2'd0) && !i_flush;
        o_tdata      = head_q;
        o_occupancy  = occ_q;
        o_beat_count = beat_q;
        pop          = i_rrst_n && !i_rempty && !i_flush && (occ_q != 2'd2);
        o_rinc       = pop;
        fire         = o_tvalid && i_tready;
    end

    // Next-state: buffer update table, flush discard and beat counting.
    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        beat_d = beat_q;
        if (fire) begin
            beat_d = beat_q + 1'b1;
        end
        if (i_flush) begin
            // Buffered words are dropped; pop and fire are both blocked here.
            occ_d  = 2'd0;
            head_d = '0;
            tail_d = '0;
        end else begin
            case (occ_q)
                2'd0: begin
                    if (pop) begin
                        head_d = i_rdata;
                        occ_d  = 2'd1;
                    end
                end
                2'd1: begin
                    if (pop && fire) begin
                        head_d = i_rdata;        // sustained one word per cycle
                    end else if (pop) begin
                        tail_d = i_rdata;
                        occ_d  = 2'd2;
                    end else if (fire) begin
                        occ_d  = 2'd0;
                    end
                end
                2'd2: begin
                    if (fire) begin
                        head_d = tail_q;         // skid entry moves to the head
                        occ_d  = 2'd1;
                    end
                end
                default: begin
                    occ_d = 2'd0;
                end
            endcase
        end
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge i_rclk or negedge i_rrst_n) begin
        if (!i_rrst_n) begin
            occ_q  <= 2'd0;
            head_q <= '0;
            tail_q <= '0;
            beat_q <= '0;
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
            tail_q <= tail_d;
            beat_q <= beat_d;
        end
    end

endmodule

// File: tb/tb_async_fifo_rd_stream.sv
// Directed bench for async_fifo_rd_stream. A queue stands in for the async FIFO
// show-ahead port; each step drives inputs, checks outputs, then advances a clock.
module tb_async_fifo_rd_stream;

    localparam int DW = 8;
    localparam int CW = 16;

    logic          i_rclk;
    logic          i_rrst_n;
    logic [DW-1:0] i_rdata;
    logic          i_rempty;
    logic          o_rinc;
    logic [DW-1:0] o_tdata;
    logic          o_tvalid;
    logic          i_tready;
    logic          i_flush;
    logic [1:0]    o_occupancy;
    logic [CW-1:0] o_beat_count;

    logic [DW-1:0] src_q[$];
    int            checks;
    int            errors;
    int            idx;

    async_fifo_rd_stream #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
        .i_rclk       (i_rclk),
        .i_rrst_n     (i_rrst_n),
        .i_rdata      (i_rdata),
        .i_rempty     (i_rempty),
        .o_rinc       (o_rinc),
        .o_tdata      (o_tdata),
        .o_tvalid     (o_tvalid),
        .i_tready     (i_tready),
        .i_flush      (i_flush),
        .o_occupancy  (o_occupancy),
        .o_beat_count (o_beat_count)
    );

    // Clock
    initial i_rclk = 1'b0;
    always #5 i_rclk = ~i_rclk;

    task automatic update_src();
        i_rempty = (src_q.size() == 0);
        i_rdata  = (src_q.size() == 0) ? '0 : src_q[0];
    endtask

    // Sample the pop strobe just before the edge, then retire the popped word.
    task automatic tick();
        logic pop_now;
        #2;
        pop_now = o_rinc;
        @(posedge i_rclk);
        #1;
        if (pop_now && src_q.size() > 0) src_q.delete(0);
        update_src();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        i_rrst_n = 1'b0;
        i_tready = 1'b0;
        i_flush  = 1'b0;
        update_src();
        repeat (2) @(posedge i_rclk);
        #1;

        // Reset state, with the FIFO already non-empty
        src_q = '{8'h11, 8'h22, 8'h33};
        update_src();
        i_tready = 1'b1;
        #1;
        chk("rst_rinc", o_rinc, 0);
        chk("rst_tvalid", o_tvalid, 0);
        chk("rst_tdata", o_tdata, 0);
        chk("rst_occ", o_occupancy, 0);
        chk("rst_beat", o_beat_count, 0);

        // Test 1: three words, ready high
        i_rrst_n = 1'b1;
        #1;
        chk("t1_rinc0", o_rinc, 1);
        chk("t1_tvalid0", o_tvalid, 0);
        tick();
        #1;
        chk("t1_tdata1", o_tdata, 8'h11);
        chk("t1_tvalid1", o_tvalid, 1);
        chk("t1_rinc1", o_rinc, 1);
        tick();
        #1;
        chk("t1_tdata2", o_tdata, 8'h22);
        chk("t1_rinc2", o_rinc, 1);
        tick();
        #1;
        chk("t1_tdata3", o_tdata, 8'h33);
        chk("t1_rinc3", o_rinc, 0);
        tick();
        #1;
        chk("t1_occ", o_occupancy, 0);
        chk("t1_beat", o_beat_count, 3);
        chk("t1_tvalid_end", o_tvalid, 0);

        // Test 2: ready low fills both slots, then drains without gaps
        i_tready = 1'b0;
        src_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
        update_src();
        #1;
        chk("t2_rinc0", o_rinc, 1);
        tick();
        #1;
        chk("t2_rinc1", o_rinc, 1);
        chk("t2_occ1", o_occupancy, 1);
        tick();
        #1;
        chk("t2_rinc2", o_rinc, 0);
        chk("t2_occ2", o_occupancy, 2);
        chk("t2_tdata_hold", o_tdata, 8'hA0);
        tick();
        #1;
        chk("t2_occ_hold", o_occupancy, 2);
        chk("t2_tdata_hold2", o_tdata, 8'hA0);
        chk("t2_rinc_hold", o_rinc, 0);
        i_tready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("t2_stream_valid", o_tvalid, 1);
            chk("t2_stream_data", o_tdata, 8'hA0 + k);
            tick();
        end
        #1;
        chk("t2_occ_end", o_occupancy, 0);
        chk("t2_beat", o_beat_count, 8);

        // Test 3: ready alternates every cycle over eight words
        src_q = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6, 8'hC7};
        update_src();
        idx = 0;
        for (int c = 0; c < 40; c++) begin
            i_tready = (c % 2 == 0);
            #1;
            if (o_tvalid && i_tready) begin
                chk("t3_order", o_tdata, 8'hC0 + idx);
                idx++;
            end
            chk("t3_occ_le2", (o_occupancy <= 2'd2), 1);
            tick();
        end
        i_tready = 1'b0;
        #1;
        chk("t3_count_words", idx, 8);
        chk("t3_beat", o_beat_count, 16);
        chk("t3_occ_end", o_occupancy, 0);

        // Test 4: flush at occupancy 2
        src_q = '{8'h55, 8'h66, 8'h77};
        update_src();
        tick();
        tick();
        #1;
        chk("t4_occ2", o_occupancy, 2);
        chk("t4_tdata", o_tdata, 8'h55);
        i_flush = 1'b1;
        #1;
        chk("t4_flush_tvalid", o_tvalid, 0);
        chk("t4_flush_rinc", o_rinc, 0);
        tick();
        i_flush = 1'b0;
        #1;
        chk("t4_occ0", o_occupancy, 0);
        chk("t4_tvalid0", o_tvalid, 0);
        chk("t4_rinc_next", o_rinc, 1);
        chk("t4_beat_kept", o_beat_count, 16);
        tick();
        #1;
        chk("t4_next_data", o_tdata, 8'h77);
        chk("t4_next_valid", o_tvalid, 1);
        i_tready = 1'b1;
        tick();
        #1;
        chk("t4_beat", o_beat_count, 17);
        chk("t4_occ_end", o_occupancy, 0);

        // Test 5: beat counter wrap (65518 more beats reach 0xFFFF)
        for (int i = 0; i < 65518; i++) src_q.push_back(DW'(i));
        update_src();
        for (int i = 0; i < 65519; i++) tick();
        #1;
        chk("t5_beat_max", o_beat_count, 16'hFFFF);
        chk("t5_occ", o_occupancy, 0);
        src_q = '{8'hB1, 8'hB2};
        update_src();
        tick();
        tick();
        #1;
        chk("t5_beat_wrap0", o_beat_count, 16'h0000);
        chk("t5_tdata", o_tdata, 8'hB2);
        tick();
        #1;
        chk("t5_beat_wrap1", o_beat_count, 16'h0001);

        // Test 6: asynchronous reset mid-stream at occupancy 2
        i_tready = 1'b0;
        src_q = '{8'hE1, 8'hE2, 8'hE3};
        update_src();
        tick();
        tick();
        #1;
        chk("t6_occ2", o_occupancy, 2);
        chk("t6_tdata_pre", o_tdata, 8'hE1);
        i_rrst_n = 1'b0;
        #1;
        chk("t6_rst_tdata", o_tdata, 0);
        chk("t6_rst_tvalid", o_tvalid, 0);
        chk("t6_rst_occ", o_occupancy, 0);
        chk("t6_rst_beat", o_beat_count, 0);
        chk("t6_rst_rinc", o_rinc, 0);
        tick();
        #1;
        chk("t6_rst_rinc_edge", o_rinc, 0);
        chk("t6_rst_occ_edge", o_occupancy, 0);
        i_rrst_n = 1'b1;
        #1;
        chk("t6_rel_rinc", o_rinc, 1);
        i_tready = 1'b1;
        tick();
        #1;
        chk("t6_rel_tdata", o_tdata, 8'hE3);
        chk("t6_rel_tvalid", o_tvalid, 1);
        tick();
        #1;
        chk("t6_rel_beat", o_beat_count, 1);
        chk("t6_rel_occ", o_occupancy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
